// File: rtl/axis_output_arbiter_pkg.sv
// Shared AXI-Stream types, routing-header ID and arbiter state for the router output stage.
// Payload widths are fixed here so every lane, demux and arbiter agrees on one layout.
package axis_output_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 4;
  localparam int USER_WIDTH = 4;

  // TID value that marks the first flit of a packet.
  localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = 4'hA;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  typedef struct packed {
    logic       tvalid;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/axis_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping at N-1.
// Pure function of its inputs so other arbiters can reuse it with their own state.
module axis_output_arbiter_rr_pick #(
  parameter int N  = 5,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] rr_ptr_i,
  output logic [GW-1:0] winner_o,
  output logic          any_req_o
);

  logic found;
  int   idx;

  // NOTE: every output and temporary gets a default first, so no path leaves a latch behind.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        winner_o = GW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_output_arbiter.sv
// Packet-level round-robin merge of INPUT_NUMBER AXI-Stream lanes onto one output.
// Optional macro ARB_PMU_EN adds saturating packet and stall counters.
module axis_output_arbiter
  import axis_output_arbiter_pkg::*;
#(
  parameter int INPUT_NUMBER = 5,
  parameter int GRANT_WIDTH  = (INPUT_NUMBER > 1) ? $clog2(INPUT_NUMBER) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  axis_mosi_t             in_mosi_i [INPUT_NUMBER],
  output axis_miso_t             in_miso_o [INPUT_NUMBER],
  output axis_mosi_t             out_mosi_o,
  input  axis_miso_t             out_miso_i,
  output logic [GRANT_WIDTH-1:0] grant_o,
  output logic                   grant_valid_o
`ifdef ARB_PMU_EN
  ,
  output logic [31:0]            pkt_count_o,
  output logic [31:0]            stall_count_o
`endif
);

  arb_state_t              state_q;
  logic [GRANT_WIDTH-1:0]  grant_q;
  logic                    grant_valid_q;
  logic [GRANT_WIDTH-1:0]  rr_ptr_q;

  logic [INPUT_NUMBER-1:0] req;
  logic [GRANT_WIDTH-1:0]  winner;
  logic                    any_req;
  logic                    xfer;
  logic                    last_xfer;

  always_comb begin
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      req[i] = in_mosi_i[i].tvalid && (in_mosi_i[i].data.tid == ROUTING_HEADER);
    end
  end

  axis_output_arbiter_rr_pick #(
    .N  (INPUT_NUMBER),
    .GW (GRANT_WIDTH)
  ) u_rr_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // The locked lane is a straight wire to the output; IDLE forwards nothing.
  always_comb begin
    out_mosi_o = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) in_miso_o[i] = '0;
    if (state_q == LOCKED) begin
      out_mosi_o          = in_mosi_i[grant_q];
      in_miso_o[grant_q]  = out_miso_i;
    end
  end

  assign xfer      = (state_q == LOCKED) && out_mosi_o.tvalid && out_miso_i.tready;
  assign last_xfer = xfer && out_mosi_o.data.tlast;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q       <= winner;
            grant_valid_q <= 1'b1;
            state_q       <= LOCKED;
          end
        end
        LOCKED: begin
          if (last_xfer) begin
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
            rr_ptr_q      <= (grant_q == GRANT_WIDTH'(INPUT_NUMBER - 1)) ? '0 : grant_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;

`ifdef ARB_PMU_EN
  logic [31:0] pkt_count_q,   pkt_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        stall;

  assign stall = (state_q == LOCKED) && out_mosi_o.tvalid && !out_miso_i.tready;

  always_comb begin
    pkt_count_d   = last_xfer ? sat_inc(pkt_count_q)   : pkt_count_q;
    stall_count_d = stall     ? sat_inc(stall_count_q) : stall_count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count_o   = pkt_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_axis_output_arbiter.sv
// Scoreboard bench for axis_output_arbiter: directed packets per lane, monitor compares output flits.
// Build with ARB_PMU_EN defined to also check the packet and stall counters.
module tb_axis_output_arbiter;
  import axis_output_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int GW = 3;

  logic          clk = 1'b0;
  logic          rst;
  axis_mosi_t    in_mosi [N];
  axis_miso_t    in_miso [N];
  axis_mosi_t    out_mosi;
  axis_miso_t    out_miso;
  logic [GW-1:0] grant;
  logic          gv;
`ifdef ARB_PMU_EN
  logic [31:0]   pkt_count;
  logic [31:0]   stall_count;
`endif

  axis_output_arbiter #(.INPUT_NUMBER(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_mosi_i     (in_mosi),
    .in_miso_o     (in_miso),
    .out_mosi_o    (out_mosi),
    .out_miso_i    (out_miso),
    .grant_o       (grant),
    .grant_valid_o (gv)
`ifdef ARB_PMU_EN
    ,
    .pkt_count_o   (pkt_count),
    .stall_count_o (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    axis_data_t data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   xfer_count = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic axis_mosi_t mk_flit(input int lane, input int pkt, input int f, input int n);
    axis_mosi_t m;
    m.tvalid     = 1'b1;
    m.data.tdata = {8'(lane), 8'(pkt), 16'(f)};
    m.data.tid   = (f == 0) ? ROUTING_HEADER : 4'h0;
    m.data.tdest = 4'(lane);
    m.data.tuser = 4'(f);
    m.data.tlast = (f == n - 1);
    return m;
  endfunction

  task automatic expect_flits(input int lane, input int pkt, input int n, input int count);
    exp_t e;
    for (int f = 0; f < count; f++) begin
      axis_mosi_t m;
      m      = mk_flit(lane, pkt, f, n);
      e.lane = lane;
      e.data = m.data;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: sample mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_mosi.tvalid && out_miso.tready) begin
      xfer_count++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_flit: got tdata 0x%0h, expected no flit", out_mosi.data.tdata);
      end else begin
        e = sb_q.pop_front();
        check("out_tdata", out_mosi.data.tdata, e.data.tdata);
        check("out_tid",   32'(out_mosi.data.tid),   32'(e.data.tid));
        check("out_tlast", 32'(out_mosi.data.tlast), 32'(e.data.tlast));
        check("out_grant", 32'(grant), e.lane);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents a packet on one lane, advancing on each handshake; aborts quietly on reset.
  task automatic drive_pkt(input int lane, input int pkt, input int n);
    bit hs;
    int waited;
    for (int f = 0; f < n; f++) begin
      in_mosi[lane] = mk_flit(lane, pkt, f, n);
      hs     = 1'b0;
      waited = 0;
      while (!hs) begin
        @(negedge clk);
        if (rst) begin
          in_mosi[lane] = '0;
          return;
        end
        hs = in_miso[lane].tready;
        @(posedge clk);
        waited++;
        if (!hs && waited > 300) begin
          timeout_fail($sformatf("lane%0d_handshake", lane));
          in_mosi[lane] = '0;
          return;
        end
      end
      #1;
    end
    in_mosi[lane] = '0;
  endtask

  // Returns on the rising edge at which transfer number `target` completes.
  task automatic wait_xfers(input int target);
    int b;
    b = 0;
    while (xfer_count < target && b < 300) begin
      @(posedge clk);
      b++;
    end
    if (xfer_count < target) timeout_fail("wait_xfers");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int base;
    rst          = 1'b1;
    out_miso     = '{tready: 1'b1};
    for (int i = 0; i < N; i++) in_mosi[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_grant_valid", 32'(gv), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_out_tvalid", 32'(out_mosi.tvalid), 0);
    check("rst_out_data", 32'(out_mosi.data.tdata), 0);
    for (int i = 0; i < N; i++) check($sformatf("rst_tready%0d", i), 32'(in_miso[i].tready), 0);
`ifdef ARB_PMU_EN
    check("rst_pkt_count", pkt_count, 0);
    check("rst_stall_count", stall_count, 0);
`endif
    rst = 1'b0;
    sync();

    // Lane 2, 4-flit packet: one bubble cycle, then locked on lane 2.
    expect_flits(2, 1, 4, 4);
    fork
      drive_pkt(2, 1, 4);
      begin
        @(negedge clk);
        check("t1_bubble_gv", 32'(gv), 0);
        check("t1_bubble_tvalid", 32'(out_mosi.tvalid), 0);
        check("t1_bubble_tready2", 32'(in_miso[2].tready), 0);
        @(negedge clk);
        check("t1_locked_gv", 32'(gv), 1);
        check("t1_locked_grant", 32'(grant), 2);
      end
    join
    @(negedge clk);
    check("t1_released_gv", 32'(gv), 0);
    check("t1_grant_held", 32'(grant), 2);
    sync();

    // rr_ptr is 3: lanes 1 and 3 together -> 3 first, then 1.
    expect_flits(3, 2, 2, 2);
    expect_flits(1, 3, 2, 2);
    fork
      drive_pkt(1, 3, 2);
      drive_pkt(3, 2, 2);
    join
    sync();

    // Lane 3 alone moves rr_ptr to 4; lane 4 then stalls mid-packet for 10 cycles.
    expect_flits(3, 4, 2, 2);
    drive_pkt(3, 4, 2);
    sync();
    expect_flits(4, 5, 4, 4);
    base = xfer_count;
    fork
      drive_pkt(4, 5, 4);
      begin
        wait_xfers(base + 2);
        #1 out_miso.tready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("stall_grant", 32'(grant), 4);
          check("stall_gv", 32'(gv), 1);
          check("stall_tready4", 32'(in_miso[4].tready), 0);
        end
        @(posedge clk);
        #1 out_miso.tready = 1'b1;
      end
    join
    @(negedge clk);
`ifdef ARB_PMU_EN
    check("stall_count", stall_count, 10);
`endif
    sync();

    // rr_ptr wrapped to 0 after lane 4: lanes 0 and 4 together -> 0 first.
    expect_flits(0, 6, 2, 2);
    expect_flits(4, 7, 2, 2);
    fork
      drive_pkt(0, 6, 2);
      drive_pkt(4, 7, 2);
    join
    sync();

    // rr_ptr 0: lanes 0,1,3 served in order, 3 cycles per 2-flit packet.
    expect_flits(0, 8, 2, 2);
    expect_flits(1, 9, 2, 2);
    expect_flits(3, 10, 2, 2);
    start = cyc;
    fork
      drive_pkt(0, 8, 2);
      drive_pkt(1, 9, 2);
      drive_pkt(3, 10, 2);
    join
    check("t2_cycles", 32'(cyc - start), 9);
`ifdef ARB_PMU_EN
    check("pkt_count", pkt_count, 10);
`endif
    sync();

    // Non-header flit on lane 1 while idle is never granted.
    in_mosi[1] = mk_flit(1, 11, 1, 3);
    repeat (6) begin
      @(negedge clk);
      check("nohdr_gv", 32'(gv), 0);
      check("nohdr_tvalid", 32'(out_mosi.tvalid), 0);
      check("nohdr_tready1", 32'(in_miso[1].tready), 0);
    end
    in_mosi[1] = '0;
    sync();

    // Reset while flit 2 of a 5-flit lane 0 packet is presented.
    expect_flits(0, 12, 5, 2);
    base = xfer_count;
    fork
      drive_pkt(0, 12, 5);
      begin
        wait_xfers(base + 2);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_gv", 32'(gv), 0);
        check("rst_mid_tvalid", 32'(out_mosi.tvalid), 0);
        check("rst_mid_grant", 32'(grant), 0);
        for (int i = 0; i < N; i++) check($sformatf("rst_mid_tready%0d", i), 32'(in_miso[i].tready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    sync();

    // rr_ptr back at 0: lanes 1 and 4 together -> 1 first.
    expect_flits(1, 13, 2, 2);
    expect_flits(4, 14, 2, 2);
    fork
      drive_pkt(1, 13, 2);
      drive_pkt(4, 14, 2);
    join

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
`ifdef ARB_PMU_EN
    check("pkt_count_after_rst", pkt_count, 2);
    check("stall_count_after_rst", stall_count, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_output_arbiter.md
Name: axis_output_arbiter

Overview:
- Output-side merge stage of a router port: N input lanes (one per input port's routing demux) converge onto one AXI-Stream output.
- Packet-level round-robin arbitration. A grant is taken on a ROUTING_HEADER flit and held until the TLAST handshake, so flits of different packets never interleave.
- Exports the current grant so upstream demuxes and PMUs can track lane ownership.

Parameters:
- INPUT_NUMBER, 5, number of input lanes merged onto this output.
- GRANT_WIDTH, (INPUT_NUMBER>1 ? $clog2(INPUT_NUMBER) : 1), grant index width.
- DATA_WIDTH / ID_WIDTH / DEST_WIDTH / USER_WIDTH, 32/4/4/4, AXIS payload field widths; passed through unchanged.

Ports:
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- in_mosi_i  in  axis_mosi_t[INPUT_NUMBER]  per-lane TVALID + data.
- in_miso_o  out  axis_miso_t[INPUT_NUMBER]  per-lane TREADY.
- out_mosi_o  out  axis_mosi_t  merged output.
- out_miso_i  in  axis_miso_t  downstream TREADY.
- grant_o  out  GRANT_WIDTH  index of the locked lane.
- grant_valid_o  out  1  high while a packet is locked.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - FSM=IDLE, rr_ptr=0, grant_o=0, grant_valid_o=0.
  - All in_miso_o TREADY=0.
  - out_mosi_o all-zero, TVALID=0.
- Request: req[i] = in_mosi_i[i].TVALID && in_mosi_i[i].data.TID==ROUTING_HEADER.
- IDLE:
  - Winner = first set req[] scanning rr_ptr, rr_ptr+1, ... with wrap INPUT_NUMBER-1 -> 0.
  - If any req, register grant_o=winner, grant_valid_o=1, go to LOCKED next cycle.
  - No flit passes in IDLE: out TVALID=0 and all TREADY=0. This gives a fixed 1-cycle arbitration bubble per packet.
- LOCKED:
  - out_mosi_o = in_mosi_i[grant_o] (combinational, zero latency).
  - in_miso_o[grant_o].TREADY = out_miso_i.TREADY; all other lanes TREADY=0.
  - Transfer = out TVALID && TREADY.
  - On a transfer with TLAST=1: next state IDLE, grant_valid_o=0, rr_ptr=grant_o+1 (wraps to 0 at INPUT_NUMBER-1).
  - grant_o keeps its last value while in IDLE.
- Single-flit packet (header with TLAST=1): locked, forwarded, released. Still costs 2 cycles minimum.
- Non-header flit on an unlocked lane: never granted, held with TREADY=0, never dropped.
- A lane requesting in the same cycle a release occurs is seen in the next IDLE cycle; no same-cycle re-grant.
- Downstream stall (TREADY=0): grant held indefinitely; no timeout.
- Upstream TVALID drop mid-packet: grant held; out TVALID follows the lane.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is abandoned, and upstream must also reset.
- Fairness: a lane requesting continuously waits at most INPUT_NUMBER-1 packets.

Optional Feature:
- Macro ARB_PMU_EN.
- Defined:
  - Adds outputs pkt_count_o[31:0] and stall_count_o[31:0], both reset to 0.
  - pkt_count_o +1 on each TLAST transfer.
  - stall_count_o +1 on each LOCKED cycle with out TVALID=1 and TREADY=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Shared package/header: axis_mosi_t, axis_miso_t, ROUTING_HEADER (existing axis_type.svh); an arb_state_t enum {IDLE, LOCKED}.
- One sub-module, rr_pick: combinational INPUT_NUMBER-wide round-robin priority picker.
  - Inputs: req[], rr_ptr. Outputs: winner index, any_req.
  - Reused by other arbiters.

Test Plan:
- Lane 2 sends 4-flit packet (header, 2 data, TLAST), out TREADY=1 -> grant_valid_o rises at cycle 1, flits at out on cycles 2-5 in order, release after cycle 5, rr_ptr=3.
- Lanes 0,1,3 present headers together, rr_ptr=0, 2-flit packets -> served 0,1,3. Each packet takes 3 cycles including the bubble, and no flit interleaves.
- Lane 4 locked, out TREADY held 0 for 10 cycles mid-packet -> grant stays 4, no data loss, lane4 TREADY=0. With ARB_PMU_EN, stall_count_o=10.
- Lane 1 presents a non-header data flit while IDLE -> never granted, in_miso_o[1].TREADY stays 0, out TVALID=0.
- rr_ptr=4, lane 4 finishes, lanes 0 and 4 request -> rr_ptr wraps to 0, lane 0 wins.
- rst_i asserted on flit 2 of a 5-flit packet -> same cycle: grant_valid_o=0, all TREADY=0, out TVALID=0. After release, a new header arbitrates from rr_ptr=0.
